// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the byte-serial 32x32 multiplier.
package mul_seq_pkg;

  localparam int NUM_STEPS = 16;
  localparam int BYTE_W    = 8;
  localparam int PROD_W    = 64;
  localparam int OP_W      = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
  function automatic logic [OP_W-1:0] magnitude(input logic [OP_W-1:0] v,
                                                 input logic          take);
    return (take && v[OP_W-1]) ? (~v + OP_W'(1)) : v;
  endfunction

endpackage

// File: rtl/multiplier_8bit.sv
// Unsigned 8x8 combinational byte multiplier.
module multiplier_8bit (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  assign p = a * b;

endmodule

// File: rtl/mul32_byte_sequencer.sv
// 32x32 signed/unsigned multiplier built from one 8x8 multiplier over
// sixteen byte-pair steps, with a valid/ready handshake on both sides.
module mul32_byte_sequencer
  import mul_seq_pkg::*;
#(
  parameter bit EARLY_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   operand_a,
  input  logic [OP_W-1:0]   operand_b,
  input  logic              signed_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product
);

  state_e             state_q, state_d;
  logic [PROD_W-1:0]  acc_q, acc_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic [OP_W-1:0]    a_q, a_d, b_q, b_d;

  logic [BYTE_W-1:0]   byte_a, byte_b;
  logic [2*BYTE_W-1:0] byte_prod;
  logic [4:0]          a_lsb, b_lsb;
  logic [2:0]          byte_pos;
  logic [PROD_W-1:0]   partial;
  logic [PROD_W-1:0]   result;

  // cnt[3:2] walks the bytes of |a|, cnt[1:0] the bytes of |b|.
  assign a_lsb    = {cnt_q[3:2], 3'b000};
  assign b_lsb    = {cnt_q[1:0], 3'b000};
  assign byte_a   = a_q[a_lsb +: BYTE_W];
  assign byte_b   = b_q[b_lsb +: BYTE_W];
  assign byte_pos = {1'b0, cnt_q[3:2]} + {1'b0, cnt_q[1:0]};
  assign partial  = {{(PROD_W-2*BYTE_W){1'b0}}, byte_prod} << {byte_pos, 3'b000};

  multiplier_8bit u_mul (
    .a (byte_a),
    .b (byte_b),
    .p (byte_prod)
  );

  always_comb begin
    // NOTE: every output and _d gets a default first; a path that skipped one would infer a latch.
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    a_d       = a_q;
    b_d       = b_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = magnitude(operand_a, signed_mode);
          b_d     = magnitude(operand_b, signed_mode);
          neg_d   = signed_mode & (operand_a[OP_W-1] ^ operand_b[OP_W-1]);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // A zero operand is resolved on the first step instead of iterating.
        if (EARLY_ZERO && (cnt_q == 4'd0) && ((a_q == '0) || (b_q == '0))) begin
          acc_d   = '0;
          neg_d   = 1'b0;
          state_d = DONE;
        end else begin
          acc_d = acc_q + partial;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'(NUM_STEPS-1)) state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!rst_n) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
    end
  end

  assign result  = neg_q ? (~acc_q + PROD_W'(1)) : acc_q;
  assign product = out_valid ? result : '0;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking here so every flop samples the pre-edge values of the others.
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

endmodule

// File: tb/tb_mul32_byte_sequencer.sv
// Scoreboard bench: the driver queues expected products and latencies, a
// negedge monitor pops and compares whenever a product is handed over.
module tb_mul32_byte_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        signed_mode = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        in_ready, out_valid;
  logic [63:0] product;
  logic        nz_in_ready, nz_out_valid;
  logic [63:0] nz_product;

  always #5 clk = ~clk;

  mul32_byte_sequencer #(.EARLY_ZERO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .operand_a(operand_a), .operand_b(operand_b), .signed_mode(signed_mode),
    .out_valid(out_valid), .out_ready(out_ready), .product(product)
  );

  mul32_byte_sequencer #(.EARLY_ZERO(1'b0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(nz_in_ready),
    .operand_a(operand_a), .operand_b(operand_b), .signed_mode(signed_mode),
    .out_valid(nz_out_valid), .out_ready(out_ready), .product(nz_product)
  );

  typedef struct {
    logic [63:0] prod;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  int   ready_mode = 0;  // 0: always ready, 1: random stalls, 2: held low

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h, required 0x%016h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic sm);
    logic signed [63:0] sa, sb;
    if (sm) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    return {32'h0, a} * {32'h0, b};
  endfunction

  // Monitor: latency on first out_valid, stability while stalled, value on handshake.
  logic        seen = 1'b0;
  logic        check_idle = 1'b0;
  logic [63:0] first_prod = '0;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (rst_n) begin
      if (check_idle) begin
        check("in_ready after handshake", 64'(in_ready), 64'd1);
        check_idle = 1'b0;
      end
      if (out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          first_prod = product;
          check("pending ops at out_valid", 64'(exp_q.size()), 64'd1);
          if (exp_q.size() > 0) check("latency", 64'(cyc - accept_cyc), 64'(exp_q[0].lat));
        end else begin
          check("product stable", product, first_prod);
        end
        check("in_ready low in DONE", 64'(in_ready), 64'd0);
        if (out_ready) begin
          if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("product", product, mon_e.prod);
          end
          seen = 1'b0;
          check_idle = 1'b1;
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sm,
                       input logic [63:0] exp_p, input int lat, input bit expect_out);
    int guard = 0;
    exp_t e;
    @(negedge clk);
    while (!(in_ready && nz_in_ready) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) begin
      check("issue wait for in_ready", 64'(guard), 64'd0);
      return;
    end
    operand_a   = a;
    operand_b   = b;
    signed_mode = sm;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    if (expect_out) begin
      e.prod = exp_p;
      e.lat  = lat;
      exp_q.push_back(e);
    end
    in_valid    = 1'b0;
    operand_a   = $urandom;
    operand_b   = $urandom;
    signed_mode = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || !in_ready || !nz_in_ready) && g < 400) begin
      @(negedge clk);
      g++;
    end
    if (g >= 400) check("drain timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    int          n;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", 64'(in_ready), 64'd0);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset product", product, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle in_ready", 64'(in_ready), 64'd1);
    check("idle out_valid", 64'(out_valid), 64'd0);

    // Largest unsigned operands, with garbage in_valid while running.
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 16, 1'b1);
    in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1 in_valid = 1'b0;
    drain();

    issue(32'hFFFF_FFFF, 32'h0000_0005, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 16, 1'b1);
    issue(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 16, 1'b1);
    issue(32'h8000_0000, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_8000_0000, 16, 1'b1);
    issue(32'h8000_0000, 32'h0000_0002, 1'b0, 64'h0000_0001_0000_0000, 16, 1'b1);
    issue(32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 16, 1'b1);
    drain();

    // Zero operand: one step with early zero, full sixteen without.
    issue(32'h0000_0000, 32'h0000_1234, 1'b0, 64'd0, 1, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!nz_out_valid && n < 40);
    check("no-early-zero latency", 64'(cyc - accept_cyc), 64'd16);
    check("no-early-zero product", nz_product, 64'd0);
    drain();
    issue(32'hFFFF_FFFB, 32'h0000_0000, 1'b1, 64'd0, 1, 1'b1);
    drain();

    // Consumer stalls five cycles in DONE.
    ready_mode = 2;
    issue(32'h0000_FFFF, 32'h0001_0001, 1'b0, 64'h0000_0000_FFFF_FFFF, 16, 1'b1);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check("stalled out_valid", 64'(out_valid), 64'd1);
    check("stalled product", product, 64'h0000_0000_FFFF_FFFF);
    check("stalled in_ready", 64'(in_ready), 64'd0);
    ready_mode = 0;
    drain();

    // Reset mid-run abandons the operation.
    issue(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 64'd0, 16, 1'b0);
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("run reset out_valid", 64'(out_valid), 64'd0);
    check("run reset in_ready", 64'(in_ready), 64'd0);
    check("run reset product", product, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post reset in_ready", 64'(in_ready), 64'd1);
    check("post reset out_valid", 64'(out_valid), 64'd0);
    issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 64'h0B00_EA4E_242D_2080, 16, 1'b1);
    drain();

    // Random operands in both modes with random consumer stalls.
    ready_mode = 1;
    for (int k = 0; k < 1000; k++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) ra = 32'h0;
      if ($urandom_range(0, 7) == 0)  rb = 32'h8000_0000;
      issue(ra, rb, rs, ref_mul(ra, rb, rs), (ra == 0 || rb == 0) ? 1 : 16, 1'b1);
    end
    drain();
    ready_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
